// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// mode encodings, stage-count derivation and the full-adder bit cell.
package pipelined_addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int unsigned MAX_STAGES = 8;

    function automatic int unsigned stages_of(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width % chunk == 0) &&
               (width / chunk >= 1) && (width / chunk <= MAX_STAGES);
    endfunction

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry segment built from full-adder cells;
// also exposes the carry into the MSB for signed-overflow detection.
module adder_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple segment per stage,
// registered carry between stages, skew/deskew chains and valid/ready handshake.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned STAGES = stages_of(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("pipelined_addsub: WIDTH must be a multiple of CHUNK giving 1..8 stages");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;

    // Subtraction is A + ~B + ~borrow_in; mode is folded in before stage 0.
    assign b_eff    = (sub == SUB) ? ~in2 : in2;
    assign carry0   = (sub == SUB) ? ~c_in : c_in;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO  = k * CHUNK;
        localparam int unsigned REM = WIDTH - LO;

        logic [REM-1:0]      a_src;
        logic [REM-1:0]      b_src;
        logic                c_src;
        logic                v_src;
        logic [CHUNK-1:0]    s_k;
        logic                cout_k;
        logic [LO+CHUNK-1:0] s_d;
        logic [LO+CHUNK-1:0] s_q;
        logic                c_q;
        logic                v_q;

        if (k == 0) begin : g_head
            assign a_src = in1;
            assign b_src = b_eff;
            assign c_src = carry0;
            assign v_src = in_valid;
            assign s_d   = s_k;
        end else begin : g_body
            assign a_src = g_stage[k-1].g_skew.a_q;
            assign b_src = g_stage[k-1].g_skew.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_d   = {s_k, g_stage[k-1].s_q};
        end

        if (k == STAGES - 1) begin : g_tail
            logic c_msb_k;
            logic ovf_q;

            adder_chunk #(
                .CHUNK(CHUNK)
            ) u_chunk (
                .a    (a_src[CHUNK-1:0]),
                .b    (b_src[CHUNK-1:0]),
                .cin  (c_src),
                .s    (s_k),
                .cout (cout_k),
                .c_msb(c_msb_k)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb_k ^ cout_k;
                end
            end
        end else begin : g_skew
            // Operand chunks not yet consumed ride along with the beat.
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            adder_chunk #(
                .CHUNK(CHUNK)
            ) u_chunk (
                .a    (a_src[CHUNK-1:0]),
                .b    (b_src[CHUNK-1:0]),
                .cin  (c_src),
                .s    (s_k),
                .cout (cout_k),
                .c_msb()
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[REM-1:CHUNK];
                    b_q <= b_src[REM-1:CHUNK];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_src;
                c_q <= cout_k;
                s_q <= s_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign c_out     = g_stage[STAGES-1].c_q;
    assign overflow  = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, CHUNK=8, latency 4)
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_addsub;
    import pipelined_addsub_pkg::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        overflow;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    pipelined_addsub #(
        .WIDTH(32),
        .CHUNK(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Integer arithmetic from the mode rules: unsigned for carry/borrow, signed for overflow.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        res_t            r;
        longint unsigned u;
        longint          v;
        if (sb == ADD) begin
            u   = 64'(a) + 64'(b) + 64'(ci);
            r.s = u[31:0];
            r.c = u[32];
            v   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end else begin
            r.s = a - b - 32'(ci);
            r.c = (64'(a) >= 64'(b) + 64'(ci));
            v   = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
        end
        r.o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat into an empty pipe and reports latency and the first result seen.
    task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic ci,
                            input logic sb, output int lat, output res_t got);
        in1       = a;
        in2       = b;
        c_in      = ci;
        sub       = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in1      = $urandom;
        in2      = $urandom;
        lat      = -1;
        got      = '0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (out_valid) begin
                lat = i;
                got = '{sum, c_out, overflow};
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in1       = $urandom;
        in2       = $urandom;
        repeat (3) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if ({sum, c_out, overflow} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sum=%h c=%b ov=%b want all 0", sum, c_out, overflow);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic run_table(input string tag, input vec_t tbl[3]);
        int   lat;
        res_t got;
        res_t want;
        for (int i = 0; i < 3; i++) begin
            tick();
            send_one(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, lat, got);
            want = '{tbl[i].s, tbl[i].c, tbl[i].o};
            n_checks++;
            if (lat != LAT) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d want %0d", tag, i, lat, LAT);
            end
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s_result[%0d]: got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                         tag, i, got.s, got.c, got.o, want.s, want.c, want.o);
            end
        end
    endtask

    task automatic test_add();
        vec_t tbl[3];
        tbl[0] = '{32'd102, 32'd103, 1'b0, ADD, 32'd205, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, ADD, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD, 32'h8000_0000, 1'b0, 1'b1};
        run_table("add", tbl);
    endtask

    task automatic test_sub();
        vec_t tbl[3];
        tbl[0] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, SUB, 32'h8000_0000, 1'b0, 1'b1};
        tbl[1] = '{32'd5, 32'd7, 1'b0, SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{32'd10, 32'd3, 1'b1, SUB, 32'd6, 1'b1, 1'b0};
        run_table("sub", tbl);
    endtask

    task automatic test_back_to_back();
        int   first = -1;
        int   n_out = 0;
        res_t r;
        exp_q.delete();
        tick();
        for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1;
                in1      = $urandom;
                in2      = $urandom;
                c_in     = 1'($urandom_range(0, 1));
                sub      = cyc[0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (first < 0) first = cyc;
                n_checks++;
                if (cyc != first + n_out) begin
                    n_fail++;
                    $display("FAIL b2b_gap: result %0d at cycle %0d want %0d", n_out, cyc,
                             first + n_out);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got unexpected result sum=%h want none", sum);
                end else begin
                    r = exp_q.pop_front();
                    if ({sum, c_out, overflow} !== r) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                                 n_out, sum, c_out, overflow, r.s, r.c, r.o);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2, c_in, sub));
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_out != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 8", n_out);
        end
        n_checks++;
        if (first != LAT) begin
            n_fail++;
            $display("FAIL b2b_first: got first result at cycle %0d want %0d", first, LAT);
        end
    endtask

    task automatic test_stall();
        int   drained = 0;
        int   expect_drain = 0;
        res_t r;
        res_t held = '0;
        exp_q.delete();
        tick();
        for (int cyc = 0; cyc < 32; cyc++) begin
            in1  = $urandom;
            in2  = $urandom;
            c_in = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            if (cyc < 6) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end else if (cyc < 11) begin
                in_valid  = 1'b1;
                out_ready = 1'b0;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (cyc >= 6 && cyc < 11) begin
                if (cyc == 6) begin
                    held         = '{sum, c_out, overflow};
                    expect_drain = exp_q.size();
                end
                n_checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_handshake[%0d]: got in_ready=%b out_valid=%b want 0 1",
                             cyc, in_ready, out_valid);
                end
                n_checks++;
                if ({sum, c_out, overflow} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d]: got sum=%h want sum=%h", cyc, sum, held.s);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_extra: got unexpected result sum=%h want none", sum);
                end else begin
                    r = exp_q.pop_front();
                    if ({sum, c_out, overflow} !== r) begin
                        n_fail++;
                        $display("FAIL stall_result[%0d]: got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                                 cyc, sum, c_out, overflow, r.s, r.c, r.o);
                    end
                end
                if (cyc >= 11) drained++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2, c_in, sub));
            tick();
        end
        n_checks++;
        if (drained != expect_drain || expect_drain != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: got drained=%0d held=%0d left=%0d want 4 4 0",
                     drained, expect_drain, exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        int   lat;
        res_t got;
        tick();
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in1       = $urandom;
            in2       = $urandom;
            rst       = (cyc == 3);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        exp_q.delete();
        tick();
        send_one(32'd141, 32'd114, 1'b0, ADD, lat, got);
        n_checks++;
        if (lat != LAT || got !== res_t'{32'd255, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_beat: got lat=%0d sum=%h c=%b ov=%b want lat=%0d sum=000000ff c=0 ov=0",
                     lat, got.s, got.c, got.o, LAT);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale[%0d]: got out_valid=%b sum=%h want 0", i, out_valid, sum);
            end
        end
    endtask

    task automatic test_random();
        res_t r;
        res_t held = '0;
        logic hold_pending = 1'b0;
        exp_q.delete();
        tick();
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in1  = pick();
            in2  = pick();
            c_in = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready,
                         !out_valid || out_ready);
            end
            if (hold_pending) begin
                n_checks++;
                if (out_valid !== 1'b1 || {sum, c_out, overflow} !== held) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: got v=%b sum=%h want v=1 sum=%h", cyc,
                             out_valid, sum, held.s);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra[%0d]: got sum=%h want none", cyc, sum);
                end else begin
                    r = exp_q.pop_front();
                    if ({sum, c_out, overflow} !== r) begin
                        n_fail++;
                        $display("FAIL rand_result[%0d]: got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                                 cyc, sum, c_out, overflow, r.s, r.c, r.o);
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held         = '{sum, c_out, overflow};
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2, c_in, sub));
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: got %0d results outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        c_in      = 1'b0;
        sub       = ADD;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
